// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: round-robin owner selection for a single shared buzzer.
//
// Four requesters ask for the buzzer with level-sensitive req bits. One owner
// at a time is granted and plays for at least min_hold en ticks. A contended
// owner is preempted after max_hold ticks. An optional silent gap of gap ticks
// separates consecutive grants. All durations count en strobes, not clocks.
//
// Ports:
//   clk       in   clock; all state changes on its rising edge
//   reset     in   synchronous active-high reset
//   en        in   one-cycle timing strobe used for all hold/gap counting
//   req[3:0]  in   per-requester note request, level-sensitive
//   grant[3:0] out registered one-hot grant, zero when nobody owns the buzzer
//   note_idx  out  registered binary index of the owner, zero when idle
//   tone_en   out  registered, high while playing
//   busy      out  registered, high while playing or in the gap
module buzzer_arbiter #(
  parameter int unsigned min_hold = 8,
  parameter int unsigned max_hold = 32,
  parameter int unsigned gap      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] note_idx,
  output logic       tone_en,
  output logic       busy
);

  localparam logic [7:0] MinHold = 8'(min_hold);
  localparam logic [7:0] MaxHold = 8'(max_hold);
  localparam logic [7:0] GapLen  = 8'(gap);
  localparam bit         HasGap  = (gap != 0);

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StGap
  } state_e;

  state_e     state_q;
  logic [7:0] cnt_q;   // en ticks since the current grant started
  logic [7:0] gcnt_q;  // en ticks spent in the gap
  logic [1:0] last_q;  // index of the most recent grant

  // Round-robin search: candidates last+1, last+2, last+3, last (mod 4).
  // Walking the order backwards lets the earliest set candidate win.
  logic [1:0] cand;
  logic [1:0] pick_idx;
  logic       pick_valid;

  always_comb begin
    cand       = last_q;
    pick_idx   = last_q;
    pick_valid = 1'b0;
    for (int k = 4; k >= 1; k--) begin
      cand = last_q + 2'(k);
      if (req[cand]) begin
        pick_idx   = cand;
        pick_valid = 1'b1;
      end
    end
  end

  // Release is judged on the registered tick count, so an en pulse in the
  // same cycle as a release never extends the grant.
  logic own_req;
  logic contention;
  logic release_now;

  always_comb begin
    own_req     = req[note_idx];
    contention  = |(req & ~grant);
    release_now = ((cnt_q >= MinHold) && !own_req) ||
                  ((cnt_q >= MaxHold) && contention);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      gcnt_q   <= 8'd0;
      last_q   <= 2'd3;  // first search after reset starts at index 0
      grant    <= 4'b0000;
      note_idx <= 2'd0;
      tone_en  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            grant    <= 4'b0001 << pick_idx;
            note_idx <= pick_idx;
            last_q   <= pick_idx;
            cnt_q    <= 8'd0;
            tone_en  <= 1'b1;
            busy     <= 1'b1;
            state_q  <= StPlay;
          end
        end

        StPlay: begin
          if (release_now) begin
            grant    <= 4'b0000;
            note_idx <= 2'd0;
            tone_en  <= 1'b0;
            if (HasGap) begin
              gcnt_q  <= 8'd0;
              busy    <= 1'b1;
              state_q <= StGap;
            end else begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end else if (en && (cnt_q != 8'hFF)) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end

        StGap: begin
          // Requests are ignored here; the gap always runs to completion.
          if (gcnt_q == GapLen) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (en) begin
            gcnt_q <= gcnt_q + 8'd1;
          end
        end

        default: begin
          grant    <= 4'b0000;
          note_idx <= 2'd0;
          tone_en  <= 1'b0;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Self-checking bench for buzzer_arbiter (min_hold=2, max_hold=4, gap=1).
module tb_buzzer_arbiter;

  localparam int MinHold = 2;
  localparam int MaxHold = 4;
  localparam int Gap     = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] note_idx;
  logic       tone_en;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit rand_en  = 1'b0;

  // Reference model: who owns the buzzer, for how many ticks, gap remaining.
  int owner;      // -1 when nobody owns it
  int held;       // en ticks counted during current ownership (saturating)
  int gap_left;   // en ticks still to wait in the gap
  bit in_gap;
  int prev_owner; // most recent owner, drives the rotating priority

  buzzer_arbiter #(
    .min_hold(MinHold),
    .max_hold(MaxHold),
    .gap     (Gap)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .req     (req),
    .grant   (grant),
    .note_idx(note_idx),
    .tone_en (tone_en),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic e, input logic [3:0] q);
    if (r) begin
      owner = -1; held = 0; gap_left = 0; in_gap = 0; prev_owner = 3;
    end else if (in_gap) begin
      if (gap_left == 0) in_gap = 0;
      else if (e) gap_left--;
    end else if (owner >= 0) begin
      bit done_hold;
      bit others;
      done_hold = (held >= MinHold) && !q[owner];
      others    = (q & ~(4'b0001 << owner)) != 4'b0000;
      if (done_hold || (held >= MaxHold && others)) begin
        owner = -1;
        if (Gap > 0) begin
          in_gap = 1; gap_left = Gap;
        end
      end else if (e && held < 255) begin
        held++;
      end
    end else if (q != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (prev_owner + k) % 4;
        if (q[c]) begin
          owner = c; prev_owner = c; held = 0;
          break;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    logic [1:0] en_idx;
    eg     = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
    en_idx = (owner >= 0) ? 2'(owner) : 2'd0;
    check("grant", 32'(grant), 32'(eg));
    check("note_idx", 32'(note_idx), 32'(en_idx));
    check("tone_en", 32'(tone_en), 32'(owner >= 0));
    check("busy", 32'(busy), 32'((owner >= 0) || in_gap));
    check("onehot0", 32'($countones(grant) <= 1), 32'd1);
    check("idx_vs_grant", 32'(grant == 4'b0000 ? 1'b1 : grant[note_idx]), 32'd1);
    check("tone_vs_grant", 32'(tone_en), 32'(grant != 4'b0000));
  endtask

  // One clock: drive inputs away from the edge, advance, then sample at +1.
  task automatic step(input logic r, input logic [3:0] q);
    reset = r;
    req   = q;
    en    = rand_en ? 1'($urandom_range(0, 1)) : ((cyc % 4) == 3);
    cyc++;
    @(posedge clk);
    model_update(r, en, q);
    #1;
    compare_all();
  endtask

  initial begin
    logic [3:0] seq[$];
    logic [3:0] prev_g;
    logic [3:0] rq;
    bit         held_ok;

    owner = -1; held = 0; gap_left = 0; in_gap = 0; prev_owner = 3;
    reset = 1'b1; en = 1'b0; req = 4'b0000;
    #1;

    // Reset state.
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    // Single request: grant one cycle later.
    step(1'b0, 4'b0100);
    check("first_grant", 32'(grant), 32'h4);
    check("first_idx", 32'(note_idx), 32'h2);
    check("first_tone", 32'(tone_en), 32'h1);
    check("first_busy", 32'(busy), 32'h1);
    for (int i = 0; i < 10; i++) step(1'b0, 4'b0100);
    for (int i = 0; i < 40 && busy; i++) step(1'b0, 4'b0000);
    check("idle_after_release", 32'(busy), 32'h0);

    // One-cycle pulse still holds for min_hold ticks, then the gap, then idle.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0001);
    check("pulse_grant", 32'(grant), 32'h1);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0000);
    check("pulse_still_held", 32'(grant), 32'h1);
    for (int i = 0; i < 40 && busy; i++) step(1'b0, 4'b0000);
    check("pulse_idle", 32'(busy), 32'h0);

    // All requesting: strict rotation 0,1,2,3,0.
    step(1'b1, 4'b0000);
    prev_g = 4'b0000;
    for (int i = 0; i < 140; i++) begin
      step(1'b0, 4'b1111);
      if (grant != 4'b0000 && prev_g == 4'b0000) seq.push_back(grant);
      prev_g = grant;
    end
    check("rr_count", 32'(seq.size() >= 5), 32'd1);
    if (seq.size() >= 5) begin
      check("rr_0", 32'(seq[0]), 32'h1);
      check("rr_1", 32'(seq[1]), 32'h2);
      check("rr_2", 32'(seq[2]), 32'h4);
      check("rr_3", 32'(seq[3]), 32'h8);
      check("rr_4", 32'(seq[4]), 32'h1);
    end

    // Uncontended grant is never preempted; contention then moves it.
    step(1'b1, 4'b0000);
    held_ok = 1'b1;
    for (int i = 0; i < 400; i++) begin
      step(1'b0, 4'b0010);
      if (i > 0 && grant != 4'b0010) held_ok = 1'b0;
    end
    check("no_preempt", 32'(held_ok), 32'd1);
    for (int i = 0; i < 60 && grant != 4'b1000; i++) step(1'b0, 4'b1010);
    check("preempt_to_3", 32'(grant), 32'h8);

    // Reset mid-play aborts; search restarts at index 0.
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0100);
    step(1'b0, 4'b0110);
    check("pre_abort_grant", 32'(grant), 32'h4);
    step(1'b1, 4'b0110);
    check("abort_grant", 32'(grant), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    check("abort_tone", 32'(tone_en), 32'h0);
    step(1'b0, 4'b0110);
    check("after_abort_grant", 32'(grant), 32'h2);
    check("after_abort_idx", 32'(note_idx), 32'h1);

    // Randomized traffic with random strobes and occasional reset.
    rand_en = 1'b1;
    rq = 4'b0000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) rq = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 299) == 0), rq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
